// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bus: pipeline status into the controller, stall/flush
// enables and the stall performance counter back out to the pipeline.
interface hazard_ctrl_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic [31:0]      instr_i;
  logic             idex_memread_i;
  logic [REG_W-1:0] idex_regt_i;
  logic             idex_multi_i;
  logic             branch_i;
  logic             perf_clr_i;
  logic             pcwrite_o;
  logic             ifid_write_o;
  logic             idex_write_o;
  logic             ifid_flush_o;
  logic             idex_flush_o;
  logic             exmem_flush_o;
  logic             busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output instr_i, idex_memread_i, idex_regt_i, idex_multi_i, branch_i, perf_clr_i,
    input  pcwrite_o, ifid_write_o, idex_write_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, busy_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, idex_memread_i, idex_regt_i, idex_multi_i, branch_i, perf_clr_i,
    output pcwrite_o, ifid_write_o, idex_write_o, ifid_flush_o, idex_flush_o,
           exmem_flush_o, busy_o, stall_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use stalls with optional slow-memory wait,
// multi-cycle EX holds, branch flushes and a saturating stall counter.
module hazard_ctrl_unit #(
  parameter int REG_W        = 5,
  parameter int LOAD_EXTRA   = 0,
  parameter int MULTI_LAT    = 4,
  parameter int BRANCH_IN_EX = 0,
  parameter int CNT_W        = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_ctrl_unit_if.slave  bus
);

  localparam int CW = ($clog2(MULTI_LAT) > 4) ? $clog2(MULTI_LAT) : 4;
  localparam logic [CW-1:0] MULTI_LOAD = CW'(MULTI_LAT - 2);
  localparam logic [CW-1:0] LOAD_LOAD  = CW'((LOAD_EXTRA > 0) ? LOAD_EXTRA - 1 : 0);

  typedef enum logic [1:0] {S_RUN, S_LOAD_WAIT, S_MULTI} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [REG_W-1:0] w_rs, w_rt;
  logic             w_hit;
  logic             w_pcwrite, w_ifid_write, w_idex_write;
  logic             w_ifid_flush, w_idex_flush, w_exmem_flush;

  assign w_rs  = REG_W'(bus.instr_i[25:21]);
  assign w_rt  = REG_W'(bus.instr_i[20:16]);
  assign w_hit = bus.idex_memread_i && (bus.idex_regt_i != '0) &&
                 ((bus.idex_regt_i == w_rs) || (bus.idex_regt_i == w_rt));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pcwrite     = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_flush  = 1'b0;
    w_exmem_flush = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_RUN: begin
          if (bus.idex_multi_i) begin
            w_pcwrite     = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_flush = 1'b1;
            w_cnt_nxt     = MULTI_LOAD;
            w_state_nxt   = S_MULTI;
          end else if (w_hit) begin
            w_pcwrite    = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_flush = 1'b1;
            if (LOAD_EXTRA > 0) begin
              w_cnt_nxt   = LOAD_LOAD;
              w_state_nxt = S_LOAD_WAIT;
            end
          end
        end
        S_LOAD_WAIT: begin
          w_pcwrite    = 1'b0;
          w_ifid_write = 1'b0;
          w_idex_flush = 1'b1;
          if (r_cnt == '0) w_state_nxt = S_RUN;
          else             w_cnt_nxt   = r_cnt - CW'(1);
        end
        S_MULTI: begin
          // cnt == 0 marks the cycle the op leaves EX, so nothing is held
          if (r_cnt != '0) begin
            w_pcwrite     = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_write  = 1'b0;
            w_exmem_flush = 1'b1;
            w_cnt_nxt     = r_cnt - CW'(1);
          end else begin
            w_state_nxt = S_RUN;
          end
        end
        default: w_state_nxt = S_RUN;
      endcase
      // A stalled IF/ID cannot take a branch; the branch unit re-presents it
      if (w_ifid_write && bus.branch_i) begin
        w_ifid_flush = 1'b1;
        if (BRANCH_IN_EX != 0) w_idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.perf_clr_i)               r_stall_cnt <= '0;
    else if (!w_pcwrite && r_stall_cnt != '1)  r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.pcwrite_o     = w_pcwrite;
  assign bus.ifid_write_o  = w_ifid_write;
  assign bus.idex_write_o  = w_idex_write;
  assign bus.ifid_flush_o  = w_ifid_flush;
  assign bus.idex_flush_o  = w_idex_flush;
  assign bus.exmem_flush_o = w_exmem_flush;
  assign bus.busy_o        = (r_state != S_RUN) && !rst_i;
  assign bus.stall_cnt_o   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: a default-parameter controller and one with a slow load,
// two-cycle multi op, EX-resolved branches and a 2-bit stall counter.
module tb_hazard_ctrl_unit;

  logic clk_i = 1'b0;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(16)) if_a ();
  hazard_ctrl_unit_if #(.REG_W(5), .CNT_W(2))  if_b ();

  hazard_ctrl_unit #(.REG_W(5), .LOAD_EXTRA(0), .MULTI_LAT(4), .BRANCH_IN_EX(0), .CNT_W(16)) u_dut_a (
    .clk_i (clk_i),
    .rst_i (rst_a),
    .bus   (if_a.slave)
  );

  hazard_ctrl_unit #(.REG_W(5), .LOAD_EXTRA(2), .MULTI_LAT(2), .BRANCH_IN_EX(1), .CNT_W(2)) u_dut_b (
    .clk_i (clk_i),
    .rst_i (rst_b),
    .bus   (if_b.slave)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    if_a.instr_i = '0; if_a.idex_memread_i = 1'b0; if_a.idex_regt_i = '0;
    if_a.idex_multi_i = 1'b0; if_a.branch_i = 1'b0; if_a.perf_clr_i = 1'b0;
    if_b.instr_i = '0; if_b.idex_memread_i = 1'b0; if_b.idex_regt_i = '0;
    if_b.idex_multi_i = 1'b0; if_b.branch_i = 1'b0; if_b.perf_clr_i = 1'b0;

    // Reset: outputs forced to defaults even with a multi op presented
    tick();
    if_a.idex_multi_i = 1'b1;
    settle();
    check_eq("rst_pcwrite", 32'(if_a.pcwrite_o), 32'd1);
    check_eq("rst_exmem_flush", 32'(if_a.exmem_flush_o), 32'd0);
    check_eq("rst_busy", 32'(if_a.busy_o), 32'd0);
    tick();
    rst_a = 1'b0; rst_b = 1'b0; if_a.idex_multi_i = 1'b0;
    settle();
    check_eq("rst_stall_cnt", 32'(if_a.stall_cnt_o), 32'd0);
    check_eq("rst_idex_write", 32'(if_a.idex_write_o), 32'd1);

    // DUT A: load-use hit on rs
    tick();
    if_a.idex_memread_i = 1'b1; if_a.idex_regt_i = 5'd8; if_a.instr_i = 32'h0100_0000;
    settle();
    check_eq("a_lu_pcwrite", 32'(if_a.pcwrite_o), 32'd0);
    check_eq("a_lu_ifid_write", 32'(if_a.ifid_write_o), 32'd0);
    check_eq("a_lu_idex_flush", 32'(if_a.idex_flush_o), 32'd1);
    check_eq("a_lu_idex_write", 32'(if_a.idex_write_o), 32'd1);
    check_eq("a_lu_busy", 32'(if_a.busy_o), 32'd0);
    tick();
    if_a.idex_memread_i = 1'b0;
    settle();
    check_eq("a_lu_cnt1", 32'(if_a.stall_cnt_o), 32'd1);
    check_eq("a_lu_release", 32'(if_a.pcwrite_o), 32'd1);

    // DUT A: load-use hit on rt
    tick();
    if_a.idex_memread_i = 1'b1; if_a.instr_i = 32'h0008_0000;
    settle();
    check_eq("a_lu_rt_ifid_write", 32'(if_a.ifid_write_o), 32'd0);
    tick();
    if_a.idex_memread_i = 1'b0;
    settle();
    check_eq("a_lu_cnt2", 32'(if_a.stall_cnt_o), 32'd2);

    // DUT A: $zero destination never stalls
    tick();
    if_a.idex_memread_i = 1'b1; if_a.idex_regt_i = 5'd0; if_a.instr_i = 32'h0000_0000;
    settle();
    check_eq("a_zero_pcwrite", 32'(if_a.pcwrite_o), 32'd1);
    if_a.idex_memread_i = 1'b0;

    // DUT A: multi op, MULTI_LAT = 4 -> 3 stalls then release
    tick();
    if_a.idex_multi_i = 1'b1;
    settle();
    check_eq("a_mu1_idex_write", 32'(if_a.idex_write_o), 32'd0);
    check_eq("a_mu1_exmem_flush", 32'(if_a.exmem_flush_o), 32'd1);
    check_eq("a_mu1_pcwrite", 32'(if_a.pcwrite_o), 32'd0);
    check_eq("a_mu1_busy", 32'(if_a.busy_o), 32'd0);
    tick(); settle();
    check_eq("a_mu2_idex_write", 32'(if_a.idex_write_o), 32'd0);
    check_eq("a_mu2_busy", 32'(if_a.busy_o), 32'd1);
    tick(); settle();
    check_eq("a_mu3_exmem_flush", 32'(if_a.exmem_flush_o), 32'd1);
    tick(); settle();
    check_eq("a_mu4_idex_write", 32'(if_a.idex_write_o), 32'd1);
    check_eq("a_mu4_exmem_flush", 32'(if_a.exmem_flush_o), 32'd0);
    check_eq("a_mu4_pcwrite", 32'(if_a.pcwrite_o), 32'd1);
    check_eq("a_mu4_busy", 32'(if_a.busy_o), 32'd1);
    tick();
    if_a.idex_multi_i = 1'b0;
    settle();
    check_eq("a_mu5_busy", 32'(if_a.busy_o), 32'd0);
    check_eq("a_mu5_cnt", 32'(if_a.stall_cnt_o), 32'd5);

    // DUT A: multi wins over load-use, then reset in the 2nd MULTI cycle
    tick();
    if_a.idex_multi_i = 1'b1; if_a.idex_memread_i = 1'b1;
    if_a.idex_regt_i = 5'd8; if_a.instr_i = 32'h0100_0000;
    settle();
    check_eq("a_prec_exmem_flush", 32'(if_a.exmem_flush_o), 32'd1);
    check_eq("a_prec_idex_flush", 32'(if_a.idex_flush_o), 32'd0);
    tick();
    rst_a = 1'b1;
    settle();
    check_eq("a_midrst_pcwrite", 32'(if_a.pcwrite_o), 32'd1);
    check_eq("a_midrst_exmem_flush", 32'(if_a.exmem_flush_o), 32'd0);
    check_eq("a_midrst_busy", 32'(if_a.busy_o), 32'd0);
    tick();
    rst_a = 1'b0; if_a.idex_multi_i = 1'b0; if_a.idex_memread_i = 1'b0;
    settle();
    check_eq("a_postrst_busy", 32'(if_a.busy_o), 32'd0);
    check_eq("a_postrst_cnt", 32'(if_a.stall_cnt_o), 32'd0);
    check_eq("a_postrst_pcwrite", 32'(if_a.pcwrite_o), 32'd1);

    // DUT A: branch resolved in ID flushes IF/ID only
    tick();
    if_a.branch_i = 1'b1;
    settle();
    check_eq("a_br_ifid_flush", 32'(if_a.ifid_flush_o), 32'd1);
    check_eq("a_br_idex_flush", 32'(if_a.idex_flush_o), 32'd0);
    if_a.branch_i = 1'b0;

    // DUT B: load-use with LOAD_EXTRA = 2 -> 3 stall cycles
    tick();
    if_b.idex_memread_i = 1'b1; if_b.idex_regt_i = 5'd8; if_b.instr_i = 32'h0100_0000;
    settle();
    check_eq("b_lu1_pcwrite", 32'(if_b.pcwrite_o), 32'd0);
    check_eq("b_lu1_busy", 32'(if_b.busy_o), 32'd0);
    tick();
    if_b.branch_i = 1'b1;
    settle();
    check_eq("b_lu2_busy", 32'(if_b.busy_o), 32'd1);
    check_eq("b_lu2_br_ifid_flush", 32'(if_b.ifid_flush_o), 32'd0);
    check_eq("b_lu2_idex_flush", 32'(if_b.idex_flush_o), 32'd1);
    check_eq("b_lu2_pcwrite", 32'(if_b.pcwrite_o), 32'd0);
    tick();
    if_b.branch_i = 1'b0;
    settle();
    check_eq("b_lu3_busy", 32'(if_b.busy_o), 32'd1);
    check_eq("b_lu3_pcwrite", 32'(if_b.pcwrite_o), 32'd0);
    tick();
    if_b.idex_memread_i = 1'b0;
    settle();
    check_eq("b_lu4_busy", 32'(if_b.busy_o), 32'd0);
    check_eq("b_lu4_pcwrite", 32'(if_b.pcwrite_o), 32'd1);
    check_eq("b_lu4_cnt", 32'(if_b.stall_cnt_o), 32'd3);

    // DUT B: $zero destination matched by rs = 0 is not a hazard
    tick();
    if_b.idex_memread_i = 1'b1; if_b.idex_regt_i = 5'd0; if_b.instr_i = 32'h0000_0000;
    settle();
    check_eq("b_zero_pcwrite", 32'(if_b.pcwrite_o), 32'd1);
    check_eq("b_zero_busy", 32'(if_b.busy_o), 32'd0);
    if_b.idex_memread_i = 1'b0;

    // DUT B: MULTI_LAT = 2 -> one stall, then release from MULTI; counter saturated
    tick();
    if_b.idex_multi_i = 1'b1;
    settle();
    check_eq("b_mu1_idex_write", 32'(if_b.idex_write_o), 32'd0);
    check_eq("b_mu1_busy", 32'(if_b.busy_o), 32'd0);
    tick(); settle();
    check_eq("b_mu2_idex_write", 32'(if_b.idex_write_o), 32'd1);
    check_eq("b_mu2_exmem_flush", 32'(if_b.exmem_flush_o), 32'd0);
    check_eq("b_mu2_busy", 32'(if_b.busy_o), 32'd1);
    tick();
    if_b.idex_multi_i = 1'b0;
    settle();
    check_eq("b_mu3_busy", 32'(if_b.busy_o), 32'd0);
    check_eq("b_sat_cnt", 32'(if_b.stall_cnt_o), 32'd3);

    // DUT B: counter clear
    tick();
    if_b.perf_clr_i = 1'b1;
    settle();
    tick();
    if_b.perf_clr_i = 1'b0;
    settle();
    check_eq("b_clr_cnt", 32'(if_b.stall_cnt_o), 32'd0);

    // DUT B: branch resolved in EX flushes IF/ID and ID/EX for one cycle
    tick();
    if_b.branch_i = 1'b1;
    settle();
    check_eq("b_br_ifid_flush", 32'(if_b.ifid_flush_o), 32'd1);
    check_eq("b_br_idex_flush", 32'(if_b.idex_flush_o), 32'd1);
    tick();
    if_b.branch_i = 1'b0;
    settle();
    check_eq("b_br_done_ifid_flush", 32'(if_b.ifid_flush_o), 32'd0);
    check_eq("b_br_done_idex_flush", 32'(if_b.idex_flush_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage MIPS core, replacing the single-cycle load-use/branch detector. It handles load-use stalls, including extra wait cycles for slow data memory, and multi-cycle EX operations such as mult/div by holding ID/EX. It flushes IF/ID or IF/ID plus ID/EX on a taken branch, depending on the branch-resolve stage. It sits beside the ID stage and drives the PC and pipeline-register write/flush enables.

## Interface
Parameters:
- REG_W, 5, register-address width
- LOAD_EXTRA, 0, extra stall cycles after the standard load-use bubble (0..15)
- MULTI_LAT, 4, total EX occupancy in cycles of a multi-cycle op (>=2)
- BRANCH_IN_EX, 0, 0 = branch resolved in ID, 1 = resolved in EX
- CNT_W, 16, width of stall performance counter

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  reset, synchronous, active-high
- instr_i  in  32  instruction in ID; rs = [25:21], rt = [20:16]
- idex_memread_i  in  1  ID/EX holds a load
- idex_regt_i  in  REG_W  load destination register in ID/EX
- idex_multi_i  in  1  ID/EX holds a multi-cycle op
- branch_i  in  1  branch taken (from the resolve stage per BRANCH_IN_EX)
- perf_clr_i  in  1  clear stall counter
- pcwrite_o  out  1  PC update enable
- ifid_write_o  out  1  IF/ID write enable
- idex_write_o  out  1  ID/EX write enable (0 = hold EX)
- ifid_flush_o  out  1  IF/ID flush
- idex_flush_o  out  1  bubble into ID/EX
- exmem_flush_o  out  1  bubble into EX/MEM
- busy_o  out  1  FSM not in RUN
- stall_cnt_o  out  CNT_W  saturating count of cycles with pcwrite_o = 0

## Operation
- FSM states: RUN, LOAD_WAIT, MULTI. One down-counter `cnt` of 4 bits or clog2(MULTI_LAT) bits, whichever is larger.
- Outputs are combinational from state and inputs.
- Defaults: pcwrite, ifid_write and idex_write = 1; all flushes = 0.
- Load-use hit: idex_memread_i && idex_regt_i != 0 && (idex_regt_i == rs || idex_regt_i == rt).
- Multi takes precedence over load-use if idex_multi_i and idex_memread_i are both 1.
- RUN with idex_multi_i:
  - Stall: pcwrite = ifid_write = idex_write = 0, exmem_flush = 1.
  - Load cnt = MULTI_LAT-2, go MULTI.
- MULTI:
  - While cnt != 0: same stall outputs, cnt decrements.
  - When cnt == 0: no stall (the op leaves EX), go RUN.
  - Total stalled cycles = MULTI_LAT-1.
- RUN with load-use hit:
  - Stall: pcwrite = ifid_write = 0, idex_flush = 1.
  - If LOAD_EXTRA > 0: load cnt = LOAD_EXTRA-1, go LOAD_WAIT; else stay in RUN.
- LOAD_WAIT:
  - Same load stall outputs every cycle.
  - When cnt == 0: go RUN; else cnt decrements.
  - The hit is re-evaluated normally in RUN afterwards.
- branch_i is honoured only in cycles where ifid_write_o = 1; otherwise it is ignored (the branch unit re-presents it).
  - Honoured, BRANCH_IN_EX = 0: ifid_flush = 1.
  - Honoured, BRANCH_IN_EX = 1: ifid_flush = 1 and idex_flush = 1.
- stall_cnt_o:
  - Increments in every cycle where pcwrite_o = 0.
  - Saturates at all-ones.
  - perf_clr_i zeroes it and takes precedence over increment.
- busy_o = (state != RUN).

## Timing
- Reset (rst_i = 1 at a clock edge): state = RUN, cnt = 0, stall_cnt_o = 0.
- While rst_i = 1, outputs are forced to defaults (no stall, no flush) and busy_o = 0.
- Reset mid-MULTI or mid-LOAD_WAIT aborts to RUN on the next edge.
- Load-use stall length = 1 + LOAD_EXTRA cycles. Multi stall length = MULTI_LAT-1 cycles.
- MULTI_LAT = 2 passes through MULTI with cnt = 0: one stall cycle, then release.
- Transitions and counter updates occur on the rising clk_i edge. Stall outputs appear in the same cycle as the detecting input (zero latency).
- stall_cnt_o reflects a stall cycle one edge after it.

## Test plan
- Default parameters. lw $t0 in ID/EX (idex_memread_i = 1, idex_regt_i = 8); instr_i rs = 8 -> one cycle with pcwrite = 0, ifid_write = 0, idex_flush = 1; stall_cnt_o = 1 next cycle.
- LOAD_EXTRA = 2, same hit -> 3 consecutive stall cycles, busy_o = 1 for the last 2 (LOAD_WAIT), then normal; idex_regt_i = 0 -> no stall.
- MULTI_LAT = 4. idex_multi_i = 1 held -> 3 cycles of idex_write = 0 and exmem_flush = 1, 4th cycle idex_write = 1, FSM back in RUN.
- BRANCH_IN_EX = 1. branch_i = 1 in RUN -> ifid_flush = idex_flush = 1 for one cycle. branch_i = 1 during a load stall -> no ifid_flush.
- rst_i asserted during the 2nd MULTI cycle -> outputs default immediately; next cycle state RUN, stall_cnt_o = 0.
- CNT_W = 2, 5 stall cycles -> stall_cnt_o saturates at 3. perf_clr_i pulse -> 0.
